mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between two masters.
// Each grant runs IDLE -> ACCESS -> DONE; requests are only sampled in IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_bus_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_e                       state_q;
  logic [3:0]                   cnt_q;
  logic                         owner_q, busy_q, en_q, we_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [1:0]                   ack_q;
  logic [1:0][DATA_WIDTH-1:0]   rdata_q;

  logic [1:0]                   req, we_in;
  logic [1:0][ADDR_WIDTH-1:0]   addr_in;
  logic [1:0][DATA_WIDTH-1:0]   wdata_in;
  logic                         gnt_d;

  assign req      = {m1_req, m0_req};
  assign we_in    = {m1_we, m0_we};
  assign addr_in  = {m1_addr, m0_addr};
  assign wdata_in = {m1_wdata, m0_wdata};

  // On contention the master that did not win last time gets the port.
  always_comb begin
    gnt_d = owner_q;
    case (req)
      2'b01:   gnt_d = 1'b0;
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ~owner_q;
      default: gnt_d = owner_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          owner_q <= gnt_d;
          busy_q  <= 1'b1;
          en_q    <= 1'b1;
          we_q    <= we_in[gnt_d];
          addr_q  <= addr_in[gnt_d];
          wdata_q <= wdata_in[gnt_d];
          cnt_q   <= LAT;
          state_q <= ACCESS;
        end
        ACCESS: begin
          en_q <= 1'b0;
          if (we_q) begin
            ack_q[owner_q] <= 1'b1;
            state_q        <= DONE;
          end else if (cnt_q == 4'd0) begin
            // Memory data is valid exactly now, MEM_LATENCY cycles after the strobe.
            rdata_q[owner_q] <= mem_rdata;
            ack_q[owner_q]   <= 1'b1;
            state_q          <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: cycle table on a MEM_LATENCY=1 instance, hand sequences
// on a MEM_LATENCY=3 instance (long read, async reset mid-read, post-reset fairness).
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, rd_val = '0;

  logic        a_m0_ack, a_m1_ack, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_m0_ack, b_m1_ack, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner));

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner));

  // Memory model: read data is only valid exactly MEM_LATENCY cycles after the strobe.
  logic [3:0] pa = '0, pb = '0;
  always @(posedge clk) begin
    pa <= {pa[2:0], a_mem_en};
    pb <= {pb[2:0], b_mem_en};
  end
  assign a_mem_rdata = pa[0] ? rd_val : 32'hBAD0BAD0;
  assign b_mem_rdata = pb[2] ? rd_val : 32'hBAD0BAD0;

  logic [133:0] a_pack, b_pack;
  assign a_pack = {a_m0_ack, a_m1_ack, a_mem_en, a_mem_we, a_busy, a_owner,
                   a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata};
  assign b_pack = {b_m0_ack, b_m1_ack, b_mem_en, b_mem_we, b_busy, b_owner,
                   b_mem_addr, b_mem_wdata, b_m0_rdata, b_m1_rdata};

  // fl = {m0_ack, m1_ack, mem_en, mem_we, busy, owner}
  typedef struct {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic [31:0] rd;
    logic [5:0] fl; logic [31:0] ea, ed, e0, e1;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic [31:0] rd, logic [5:0] fl,
                              logic [31:0] ea, logic [31:0] ed, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.rd = rd; v.fl = fl; v.ea = ea; v.ed = ed; v.e0 = e0; v.e1 = e1;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into the first cycle after reset release.
  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int acks;
    // m0 read 0x10 -> DEADBEEF
    add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF, 6'b000001, 32'h10-32'h10,32'h0,32'h0,32'h0);
    add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF, 6'b001010, 32'h10,32'h0,32'h0,32'h0);
    add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF, 6'b000010, 32'h10,32'h0,32'h0,32'h0);
    add(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF, 6'b100010, 32'h10,32'h0,32'hDEADBEEF,32'h0);
    // m1 write 0x20 <- 12345678
    add(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'hDEADBEEF, 6'b000000, 32'h10,32'h0,32'hDEADBEEF,32'h0);
    add(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'hDEADBEEF, 6'b001111, 32'h20,32'h12345678,32'hDEADBEEF,32'h0);
    add(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h20,32'h12345678, 32'hDEADBEEF, 6'b010111, 32'h20,32'h12345678,32'hDEADBEEF,32'h0);
    // both held: m0 read 0x30, m1 write 0x40, alternating grants
    for (int k = 7; k <= 20; k++) begin
      logic [31:0] rd, ea, ed, e0;
      logic [5:0]  fl;
      rd = (k < 14) ? 32'hCAFEF00D : 32'h13572468;
      case (k)
        7:  begin fl = 6'b000001; ea = 32'h20; ed = 32'h12345678; e0 = 32'hDEADBEEF; end
        8:  begin fl = 6'b001010; ea = 32'h30; ed = 32'h0;        e0 = 32'hDEADBEEF; end
        9:  begin fl = 6'b000010; ea = 32'h30; ed = 32'h0;        e0 = 32'hDEADBEEF; end
        10: begin fl = 6'b100010; ea = 32'h30; ed = 32'h0;        e0 = 32'hCAFEF00D; end
        11: begin fl = 6'b000000; ea = 32'h30; ed = 32'h0;        e0 = 32'hCAFEF00D; end
        12: begin fl = 6'b001111; ea = 32'h40; ed = 32'h55AA55AA; e0 = 32'hCAFEF00D; end
        13: begin fl = 6'b010111; ea = 32'h40; ed = 32'h55AA55AA; e0 = 32'hCAFEF00D; end
        14: begin fl = 6'b000001; ea = 32'h40; ed = 32'h55AA55AA; e0 = 32'hCAFEF00D; end
        15: begin fl = 6'b001010; ea = 32'h30; ed = 32'h0;        e0 = 32'hCAFEF00D; end
        16: begin fl = 6'b000010; ea = 32'h30; ed = 32'h0;        e0 = 32'hCAFEF00D; end
        17: begin fl = 6'b100010; ea = 32'h30; ed = 32'h0;        e0 = 32'h13572468; end
        18: begin fl = 6'b000000; ea = 32'h30; ed = 32'h0;        e0 = 32'h13572468; end
        19: begin fl = 6'b001111; ea = 32'h40; ed = 32'h55AA55AA; e0 = 32'h13572468; end
        default: begin fl = 6'b010111; ea = 32'h40; ed = 32'h55AA55AA; e0 = 32'h13572468; end
      endcase
      add(1'b1,1'b0,32'h30,32'h0, 1'b1,1'b1,32'h40,32'h55AA55AA, rd, fl, ea, ed, e0, 32'h0);
    end
    // m0 writes back-to-back, new address after the first ack
    add(1'b1,1'b1,32'h50,32'h11112222, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b000001, 32'h40,32'h55AA55AA,32'h13572468,32'h0);
    add(1'b1,1'b1,32'h50,32'h11112222, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b001110, 32'h50,32'h11112222,32'h13572468,32'h0);
    add(1'b1,1'b1,32'h50,32'h11112222, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b100110, 32'h50,32'h11112222,32'h13572468,32'h0);
    add(1'b1,1'b1,32'h60,32'h33334444, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b000000, 32'h50,32'h11112222,32'h13572468,32'h0);
    add(1'b1,1'b1,32'h60,32'h33334444, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b001110, 32'h60,32'h33334444,32'h13572468,32'h0);
    add(1'b1,1'b1,32'h60,32'h33334444, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b100110, 32'h60,32'h33334444,32'h13572468,32'h0);
    add(1'b0,1'b1,32'h60,32'h33334444, 1'b0,1'b0,32'h0,32'h0, 32'h0, 6'b000000, 32'h60,32'h33334444,32'h13572468,32'h0);

    #2 reset = 1'b1;
    #1;
    chk("reset values L1", 160'(a_pack), 160'({6'b000001, 128'h0}));
    chk("reset values L3", 160'(b_pack), 160'({6'b000001, 128'h0}));
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) cyc();
      m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
      m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
      rd_val = tbl[i].rd;
      chk($sformatf("L1 row %0d", i), 160'(a_pack),
          160'({tbl[i].fl, tbl[i].ea, tbl[i].ed, tbl[i].e0, tbl[i].e1}));
    end

    // MEM_LATENCY=3 read: strobe in cycle 1 only, capture in 4, ack in 5
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h70; rd_val = 32'hA1B2C3D4;
    cyc();
    chk("L3 c1 strobe", 160'({b_mem_en, b_mem_we, b_busy, b_owner, b_mem_addr}),
        160'({4'b1010, 32'h70}));
    cyc();
    chk("L3 c2 en/ack", 160'({b_mem_en, b_m0_ack, b_busy}), 160'(3'b001));
    cyc();
    cyc();
    chk("L3 c4 no ack yet", 160'({b_m0_ack, b_m0_rdata}), 160'({1'b0, 32'h0}));
    cyc();
    chk("L3 c5 ack rdata", 160'({b_m0_ack, b_m1_ack, b_busy, b_m0_rdata}),
        160'({3'b101, 32'hA1B2C3D4}));
    m0_req = 1'b0;
    cyc();
    chk("L3 c6 idle", 160'({b_m0_ack, b_busy}), 160'(2'b00));

    // async reset in cycle 2 of a read
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h80; rd_val = 32'h0F0F0F0F;
    cyc();
    chk("rst seq strobe", 160'({b_mem_en, b_busy}), 160'(2'b11));
    cyc();
    #3 reset = 1'b1;
    #1;
    chk("async reset", 160'({b_busy, b_mem_en, b_m0_ack, b_m1_ack, b_owner, b_mem_addr, a_busy}),
        160'({5'b00001, 32'h0, 1'b0}));
    m0_req = 1'b0;
    cyc();
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (b_m0_ack || b_m1_ack) acks++;
    end
    chk("no ack after reset", 160'(acks), 160'(0));

    // after reset, simultaneous requests: m0 (write) first, then m1 (read)
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h90; m0_wdata = 32'hABCD0001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hA0; rd_val = 32'h600DCAFE;
    cyc();
    chk("post-rst grant m0", 160'({b_owner, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata}),
        160'({3'b011, 32'h90, 32'hABCD0001}));
    cyc();
    chk("post-rst m0 ack", 160'({b_m0_ack, b_m1_ack}), 160'(2'b10));
    m0_req = 1'b0;
    cyc();
    cyc();
    chk("then grant m1", 160'({b_owner, b_mem_en, b_mem_we, b_mem_addr}), 160'({3'b110, 32'hA0}));
    cyc();
    cyc();
    cyc();
    cyc();
    chk("m1 read ack", 160'({b_m0_ack, b_m1_ack, b_m1_rdata, b_m0_rdata}),
        160'({2'b01, 32'h600DCAFE, 32'h0}));
    m1_req = 1'b0;
    cyc();
    chk("final idle", 160'({b_m0_ack, b_m1_ack, b_busy, b_owner}), 160'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
